// File: rtl/imem_boot_loader_pkg.sv
// Shared types and frame constants for the instruction-memory boot loader.
// Imported by the loader top and its word assembler.
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int LEN_W      = 8 * LEN_BYTES;

endpackage

// File: rtl/imem_boot_loader_word_assembler.sv
// Collects four little-endian bytes into one 32-bit word.
// word_valid pulses the cycle after the fourth byte is shifted in.
module imem_word_assembler
    import imem_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_shift,
    input  logic [7:0]  i_byte,
    output logic        o_last,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [1:0]  r_idx;
    logic [23:0] r_part;
    logic        r_valid;
    logic [31:0] r_word;

    assign o_last       = i_shift && (r_idx == 2'(WORD_BYTES - 1));
    assign o_word_valid = r_valid;
    assign o_word       = r_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= 2'd0;
            r_part  <= 24'd0;
            r_valid <= 1'b0;
            r_word  <= 32'd0;
        end else if (i_clr) begin
            r_idx   <= 2'd0;
            r_part  <= 24'd0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= o_last;
            if (o_last) begin
                r_word <= {i_byte, r_part};
                r_idx  <= 2'd0;
            end else if (i_shift) begin
                case (r_idx)
                    2'd0:    r_part[7:0]   <= i_byte;
                    2'd1:    r_part[15:8]  <= i_byte;
                    default: r_part[23:16] <= i_byte;
                endcase
                r_idx <= r_idx + 2'd1;
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: writes a length-prefixed, XOR-checked image
// into instruction memory and holds the core in reset until it verifies.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam logic [31:0] MAX_N = 32'(1) << ADDR_W;

    state_t             r_state;
    state_t             w_next;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_widx;
    logic [7:0]         r_csum;
    logic [ADDR_W-1:0]  r_addr;

    logic               w_xfer;
    logic               w_arm;
    logic               w_shift;
    logic               w_last;
    logic [LEN_W-1:0]   w_len;
    logic [LEN_W-1:0]   w_widx_nx;

    assign w_xfer    = byte_valid && byte_ready;
    assign w_arm     = start && (r_state inside {IDLE, DONE, ERR});
    assign w_shift   = w_xfer && (r_state == DATA);
    assign w_len     = {byte_data, r_len[7:0]};
    assign w_widx_nx = r_widx + LEN_W'(1);
    assign imem_addr = r_addr;

    imem_word_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_arm),
        .i_shift      (w_shift),
        .i_byte       (byte_data),
        .o_last       (w_last),
        .o_word_valid (imem_we),
        .o_word       (imem_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE, DONE, ERR: if (start) w_next = LEN0;
            LEN0: if (w_xfer) w_next = LEN1;
            LEN1: begin
                if (w_xfer) begin
                    if ({{(32-LEN_W){1'b0}}, w_len} > MAX_N) w_next = ERR;
                    else if (w_len == '0)                     w_next = CSUM;
                    else                                      w_next = DATA;
                end
            end
            DATA: if (w_last && (w_widx_nx == r_len)) w_next = CSUM;
            CSUM: if (w_xfer) w_next = (byte_data == r_csum) ? DONE : ERR;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        byte_ready = r_state inside {LEN0, LEN1, DATA, CSUM};
        done       = (r_state == DONE);
        error      = (r_state == ERR);
        cpu_hold   = (r_state != DONE);
    end

    // Datapath: length latch, running XOR and the write address of the word in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len  <= '0;
            r_widx <= '0;
            r_csum <= 8'd0;
            r_addr <= ADDR_W'(BASE_ADDR);
        end else if (w_arm) begin
            r_widx <= '0;
            r_csum <= 8'd0;
        end else begin
            if (w_xfer && (r_state == LEN0)) r_len[7:0]       <= byte_data;
            if (w_xfer && (r_state == LEN1)) r_len[LEN_W-1:8] <= byte_data;
            if (w_shift) r_csum <= r_csum ^ byte_data;
            if (w_last) begin
                r_addr <= ADDR_W'(BASE_ADDR) + r_widx[ADDR_W-1:0];
                r_widx <= w_widx_nx;
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: a driver queues expected writes,
// independent monitors check every imem_we against them.
module tb_imem_boot_loader;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start2;
    logic        byte_valid;
    logic [7:0]  byte_data;

    logic        byte_ready, imem_we, cpu_hold, done, error;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;

    logic        byte_ready2, imem_we2, cpu_hold2, done2, error2;
    logic [1:0]  imem_addr2;
    logic [31:0] imem_wdata2;

    wr_t         q[$];
    wr_t         q2[$];
    logic [31:0] wbuf[4];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    imem_boot_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    imem_boot_loader #(.ADDR_W(2), .BASE_ADDR(1)) dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready2), .imem_we(imem_we2),
        .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
        .cpu_hold(cpu_hold2), .done(done2), .error(error2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        wr_t e;
        if (imem_we === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected got %08h@%0h cyc %0d",
                         imem_wdata, imem_addr, cyc);
            end else begin
                e = q.pop_front();
                if (imem_addr !== e.addr || imem_wdata !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL wr got %08h@%0h cyc %0d want %08h@%0h cyc %0d",
                             imem_wdata, imem_addr, cyc, e.data, e.addr, e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        wr_t e;
        if (imem_we2 === 1'b1) begin
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL wr2_unexpected got %08h@%0h cyc %0d",
                         imem_wdata2, imem_addr2, cyc);
            end else begin
                e = q2.pop_front();
                if ({6'd0, imem_addr2} !== e.addr || imem_wdata2 !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL wr2 got %08h@%0h cyc %0d want %08h@%0h cyc %0d",
                             imem_wdata2, imem_addr2, cyc, e.data, e.addr, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic pulse_start(input bit sel);
        @(negedge clk);
        if (sel) start2 = 1'b1;
        else     start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    // c0 is the cycle count seen just before the transferring edge
    task automatic send_byte(input bit sel, input logic [7:0] b,
                             input int gap, output int c0);
        int n = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        while (!(sel ? byte_ready2 : byte_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL byte_ready_timeout got 0 want 1");
        end
        c0 = cyc;
        @(posedge clk);
        #1 byte_valid = 1'b0;
    endtask

    task automatic send_frame(input bit sel, input int n, input logic [7:0] cs,
                              input int gap, input int mid_start, input int stop_at);
        logic [15:0] nn = 16'(n);
        int c0;
        int cnt = 0;
        wr_t e;
        send_byte(sel, nn[7:0], gap, c0);
        send_byte(sel, nn[15:8], gap, c0);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 4; j++) begin
                send_byte(sel, wbuf[i][8*j +: 8], gap, c0);
                if (j == 3) begin
                    e.addr = sel ? 8'((1 + i) % 4) : 8'(i);
                    e.data = wbuf[i];
                    e.cyc  = c0 + 1;
                    if (sel) q2.push_back(e);
                    else     q.push_back(e);
                end
                cnt++;
                if (cnt == mid_start) pulse_start(sel);
                if (cnt == stop_at) return;
            end
        end
        send_byte(sel, cs, gap, c0);
    endtask

    initial begin
        int c0;
        rst = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_byte_ready", {31'd0, byte_ready}, 0);
        chk("rst_we", {31'd0, imem_we}, 0);
        chk("rst_addr", {24'd0, imem_addr}, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_cpu_hold", {31'd0, cpu_hold}, 1);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_error", {31'd0, error}, 0);
        chk("rst_addr2", {30'd0, imem_addr2}, 1);

        wbuf[0] = 32'h00A00513;
        wbuf[1] = 32'h00B00593;
        pulse_start(0);
        chk("arm_byte_ready", {31'd0, byte_ready}, 1);
        chk("arm_cpu_hold", {31'd0, cpu_hold}, 1);
        send_frame(0, 2, 8'h90, 0, -1, -1);
        @(negedge clk);
        chk("good_done", {31'd0, done}, 1);
        chk("good_cpu_hold", {31'd0, cpu_hold}, 0);
        chk("good_error", {31'd0, error}, 0);
        chk("good_byte_ready", {31'd0, byte_ready}, 0);

        pulse_start(0);
        chk("rearm_done", {31'd0, done}, 0);
        chk("rearm_cpu_hold", {31'd0, cpu_hold}, 1);
        send_frame(0, 2, 8'h91, 0, -1, -1);
        @(negedge clk);
        chk("bad_error", {31'd0, error}, 1);
        chk("bad_done", {31'd0, done}, 0);
        chk("bad_cpu_hold", {31'd0, cpu_hold}, 1);
        chk("bad_byte_ready", {31'd0, byte_ready}, 0);
        pulse_start(0);
        chk("clr_error", {31'd0, error}, 0);
        chk("clr_byte_ready", {31'd0, byte_ready}, 1);

        send_frame(0, 0, 8'h00, 0, -1, -1);
        @(negedge clk);
        chk("zero_done", {31'd0, done}, 1);

        pulse_start(1);
        send_byte(1, 8'h05, 0, c0);
        send_byte(1, 8'h00, 0, c0);
        @(negedge clk);
        chk("long_error2", {31'd0, error2}, 1);
        chk("long_byte_ready2", {31'd0, byte_ready2}, 0);
        chk("long_cpu_hold2", {31'd0, cpu_hold2}, 1);

        wbuf[0] = 32'h04030201;
        wbuf[1] = 32'h08070605;
        wbuf[2] = 32'h0C0B0A09;
        wbuf[3] = 32'h100F0E0D;
        pulse_start(1);
        send_frame(1, 4, 8'h10, 0, -1, -1);
        @(negedge clk);
        chk("full_done2", {31'd0, done2}, 1);
        chk("full_cpu_hold2", {31'd0, cpu_hold2}, 0);

        wbuf[0] = 32'h00A00513;
        wbuf[1] = 32'h00B00593;
        pulse_start(0);
        send_frame(0, 2, 8'h90, 1, 5, -1);
        @(negedge clk);
        chk("gap_done", {31'd0, done}, 1);
        chk("gap_cpu_hold", {31'd0, cpu_hold}, 0);

        pulse_start(0);
        send_frame(0, 2, 8'h00, 0, -1, 6);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_byte_ready", {31'd0, byte_ready}, 0);
        chk("abort_cpu_hold", {31'd0, cpu_hold}, 1);
        chk("abort_done", {31'd0, done}, 0);
        chk("abort_we", {31'd0, imem_we}, 0);
        repeat (6) @(negedge clk);
        chk("pending_writes", q.size(), 0);
        chk("pending_writes2", q2.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule
